dec_scheduler: RTL and testbench

DEC_SCHEDULER -- requirements
Module: dec_scheduler

---
 rtl/dec_pkg.sv | 23 ++
 rtl/dec_route.sv | 47 ++++
 rtl/dec_scheduler.sv | 121 ++++++++++++
 tb/tb_dec_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the decryption scheduler: FSM encoding, engine indices
// and the default message terminator.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] TOKEN_DEF   = 8'hFA;

  localparam logic [1:0] ENG_CAESAR  = 2'd0;
  localparam logic [1:0] ENG_SCYTALE = 2'd1;
  localparam logic [1:0] ENG_ZIGZAG  = 2'd2;
  localparam logic [1:0] ENG_INVALID = 2'd3;

  function automatic logic sel_is_engine(input logic [1:0] s);
    return s != ENG_INVALID;
  endfunction

endpackage

// File: rtl/dec_route.sv
// Per-engine output register stage: one registered data/valid pair per engine,
// only the selected engine sees a valid pulse.
module dec_route
  import dec_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sel,
  input  logic [D_WIDTH-1:0] data,
  input  logic               valid,
  output logic [D_WIDTH-1:0] data0_o,
  output logic               valid0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic               valid1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid2_o
);

  logic hit0, hit1, hit2;

  always_comb begin
    hit0 = valid && (sel == ENG_CAESAR);
    hit1 = valid && (sel == ENG_SCYTALE);
    hit2 = valid && (sel == ENG_ZIGZAG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_o  <= '0;
      valid0_o <= 1'b0;
      data1_o  <= '0;
      valid1_o <= 1'b0;
      data2_o  <= '0;
      valid2_o <= 1'b0;
    end else begin
      valid0_o <= hit0;
      valid1_o <= hit1;
      valid2_o <= hit2;
      if (hit0) data0_o <= data;
      if (hit1) data1_o <= data;
      if (hit2) data2_o <= data;
    end
  end

endmodule

// File: rtl/dec_scheduler.sv
// Message scheduler: latches an engine per message, forwards characters to it,
// then drains and holds the output mux before accepting the next message.
module dec_scheduler
  import dec_pkg::*;
#(
  parameter int unsigned         D_WIDTH   = 8,
  parameter int unsigned         MAX_CHARS = 50,
  parameter int unsigned         MUX_LAT   = 1,
  parameter logic [D_WIDTH-1:0]  TOKEN     = D_WIDTH'(TOKEN_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_select,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  output logic               busy_o,
  output logic [D_WIDTH-1:0] data0_o,
  output logic               valid0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic               valid1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid2_o,
  input  logic [2:0]         busy_i,
  output logic [1:0]         select_o,
  output logic               err_sel_o,
  output logic               err_ovf_o
);

  localparam int unsigned CNT_W = (MAX_CHARS > 0) ? $clog2(MAX_CHARS + 1) : 1;
  localparam int unsigned TMR_W = $clog2(MUX_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHARS);

  state_t           state, state_nxt;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;

  logic       accept, is_tok, room, eng_ok, eng_busy;
  logic [1:0] cur_sel;
  logic       fwd_valid, cnt_inc, ovf_hit;

  // The first character of a message routes on cfg_select directly, since sel
  // only becomes valid one cycle later.
  always_comb begin
    accept  = valid_i && (state == IDLE || state == FWD);
    is_tok  = data_i == TOKEN;
    cur_sel = (state == IDLE) ? cfg_select : sel;
    eng_ok  = sel_is_engine(cur_sel);
    room    = cnt < CNT_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eng_busy  = 1'b0;
    unique case (sel)
      ENG_CAESAR:  eng_busy = busy_i[0];
      ENG_SCYTALE: eng_busy = busy_i[1];
      ENG_ZIGZAG:  eng_busy = busy_i[2];
      default:     eng_busy = 1'b0;
    endcase
    unique case (state)
      IDLE:  if (valid_i) state_nxt = is_tok ? DRAIN : FWD;
      FWD:   if (valid_i && is_tok) state_nxt = DRAIN;
      DRAIN: if (tmr == '0 && !eng_busy) state_nxt = HOLD;
      HOLD:  if (tmr == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state == DRAIN) || (state == HOLD);
    fwd_valid = accept && eng_ok && (is_tok || room);
    cnt_inc   = accept && eng_ok && !is_tok && room;
    ovf_hit   = accept && eng_ok && !is_tok && !room;
  end

  // tmr enforces the two-cycle DRAIN minimum, then is reused to time HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= ENG_CAESAR;
      cnt       <= '0;
      tmr       <= '0;
      err_sel_o <= 1'b0;
      err_ovf_o <= 1'b0;
    end else begin
      if (state == IDLE && valid_i) sel <= cfg_select;

      if (cnt_inc)                          cnt <= cnt + CNT_W'(1);
      else if (state == HOLD && tmr == '0)  cnt <= '0;

      if (state != DRAIN && state_nxt == DRAIN)     tmr <= TMR_W'(1);
      else if (state == DRAIN && state_nxt == HOLD) tmr <= TMR_W'(MUX_LAT);
      else if (tmr != '0)                           tmr <= tmr - TMR_W'(1);

      if (state == IDLE && valid_i && !sel_is_engine(cfg_select)) err_sel_o <= 1'b1;
      if (ovf_hit) err_ovf_o <= 1'b1;
    end
  end

  assign select_o = sel;

  dec_route #(.D_WIDTH(D_WIDTH)) u_route (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (cur_sel),
    .data     (data_i),
    .valid    (fwd_valid),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .data2_o  (data2_o),
    .valid2_o (valid2_o)
  );

endmodule

// File: tb/tb_dec_scheduler.sv
// Scoreboard bench for dec_scheduler: directed scenarios plus random messages,
// expected routing pushed at stimulus time and popped by an output monitor.
module tb_dec_scheduler;
  import dec_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned MAXC = 4;
  localparam int unsigned MLAT = 2;
  localparam logic [7:0]  TOK  = 8'hFA;

  logic          clk, rst_n;
  logic [1:0]    cfg_select;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          busy_o;
  logic [DW-1:0] data0_o, data1_o, data2_o;
  logic          valid0_o, valid1_o, valid2_o;
  logic [2:0]    busy_i;
  logic [1:0]    select_o;
  logic          err_sel_o, err_ovf_o;

  dec_scheduler #(.D_WIDTH(DW), .MAX_CHARS(MAXC), .MUX_LAT(MLAT), .TOKEN(TOK)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_select(cfg_select), .data_i(data_i),
    .valid_i(valid_i), .busy_o(busy_o),
    .data0_o(data0_o), .valid0_o(valid0_o),
    .data1_o(data1_o), .valid1_o(valid1_o),
    .data2_o(data2_o), .valid2_o(valid2_o),
    .busy_i(busy_i), .select_o(select_o),
    .err_sel_o(err_sel_o), .err_ovf_o(err_ovf_o)
  );

  typedef struct {
    int unsigned eng;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned cyc        = 0;
  bit          exp_err_sel = 0;
  bit          exp_err_ovf = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: every valid pulse must match the head of the scoreboard.
  int unsigned n_valid, eng_act;
  logic [7:0]  dat_act;
  exp_t        e;
  always @(negedge clk) begin
    if (rst_n) begin
      n_valid = int'(valid0_o) + int'(valid1_o) + int'(valid2_o);
      if (n_valid != 0) begin
        check("one_valid", n_valid, 1);
        eng_act = valid0_o ? 0 : (valid1_o ? 1 : 2);
        dat_act = valid0_o ? data0_o : (valid1_o ? data1_o : data2_o);
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got eng %0d data %0h, required none", eng_act, dat_act);
        end else begin
          e = sbq.pop_front();
          check("route_eng", eng_act, e.eng);
          check("route_data", dat_act, e.data);
          check("route_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == TOK) v = 8'h00;
    return v;
  endfunction

  // Sends one message (chars ends with TOK); engine busy held high for the
  // first k busy cycles. Checks forwarding, busy duration and flags.
  task automatic send_msg(input logic [1:0] s, input logic [7:0] chars[$],
                          input int unsigned k, input bit fixed_other);
    int unsigned nfwd, exp_total, busy_cnt;
    bit done;
    exp_t x;
    nfwd = 0;
    check("idle_busy_o", busy_o, 0);
    foreach (chars[i]) begin
      cfg_select = (i == 0) ? s : (fixed_other ? 2'd2 : 2'($urandom_range(0, 3)));
      data_i     = chars[i];
      valid_i    = 1'b1;
      busy_i     = 3'($urandom_range(0, 7));
      if (s == 2'd3) exp_err_sel = 1;
      else if (chars[i] == TOK || nfwd < MAXC) begin
        x.eng = s; x.data = chars[i]; x.cyc = cyc + 1;
        sbq.push_back(x);
        if (chars[i] != TOK) nfwd++;
      end else exp_err_ovf = 1;
      tick();
      check("select_o_fwd", select_o, s);
      if (i + 1 < chars.size()) check("fwd_busy_o", busy_o, 0);
    end
    valid_i = 1'b0;
    if (s == 2'd3) exp_total = 2 + MLAT + 1;
    else exp_total = ((k + 1 > 2) ? k + 1 : 2) + MLAT + 1;
    busy_cnt = 0;
    done = 0;
    for (int unsigned c = 1; c <= exp_total + 20; c++) begin
      busy_i = 3'($urandom_range(0, 7));
      if (s != 2'd3) busy_i[s] = (c <= k);
      valid_i    = (c <= exp_total) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_i     = 8'($urandom_range(0, 255));
      cfg_select = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (!busy_o) begin
        done = 1;
        break;
      end
      busy_cnt++;
      check("select_o_busy", select_o, s);
      @(posedge clk);
      #1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: got busy after %0d cycles, required %0d", busy_cnt, exp_total);
    end
    check("busy_cycles", busy_cnt, exp_total);
    valid_i = 1'b0;
    busy_i  = 3'b000;
    @(posedge clk);
    #1;
    check("err_sel_o", err_sel_o, exp_err_sel);
    check("err_ovf_o", err_ovf_o, exp_err_ovf);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {valid2_o, valid1_o, valid0_o}, 0);
    check({tag, "_data0"}, data0_o, 0);
    check({tag, "_data1"}, data1_o, 0);
    check({tag, "_data2"}, data2_o, 0);
    check({tag, "_busy_o"}, busy_o, 0);
    check({tag, "_select_o"}, select_o, 0);
    check({tag, "_err"}, {err_sel_o, err_ovf_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m[$];
    logic [1:0] s;
    int unsigned len;
    exp_t x;

    rst_n = 1'b0; cfg_select = '0; data_i = '0; valid_i = 1'b0; busy_i = '0;
    #2;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    m = '{8'h41, 8'h42, 8'h43, TOK};
    send_msg(2'd1, m, 0, 0);

    m = '{8'h10, 8'h20, TOK};
    send_msg(2'd1, m, 5, 0);

    m = '{8'h31, 8'h32, 8'h33, TOK};
    send_msg(2'd0, m, 1, 1);

    m = '{TOK};
    send_msg(2'd2, m, 0, 0);

    m = '{8'h41, TOK};
    send_msg(2'd3, m, 3, 0);

    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, TOK};
    send_msg(2'd0, m, 0, 0);

    for (int unsigned n = 0; n < 30; n++) begin
      s   = 2'($urandom_range(0, 3));
      len = (s == 2'd3) ? $urandom_range(0, MAXC) : $urandom_range(0, MAXC + 2);
      m.delete();
      for (int unsigned j = 0; j < len; j++) m.push_back(rand_char());
      m.push_back(TOK);
      send_msg(s, m, $urandom_range(0, 4), 0);
    end

    // Abort a message mid-flight with an asynchronous reset.
    cfg_select = 2'd1; data_i = 8'h11; valid_i = 1'b1;
    x.eng = 1; x.data = 8'h11; x.cyc = cyc + 1;
    sbq.push_back(x);
    tick();
    cfg_select = 2'd0; data_i = 8'h22;
    tick();
    valid_i = 1'b0;
    check("pre_reset_data1", data1_o, 8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_err_sel = 0;
    exp_err_ovf = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, TOK};
    send_msg(2'd2, m, 0, 0);

    tick();
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
